hilo_div: RTL and testbench

- HI/LO architectural register pair plus an iterative 32-cycle divider for DIV/DIVU.
- Receives the WB-stage HI/LO write produced by the execute stage's whilo/hi/lo outputs.
- Presents current HI/LO values back to execute.
- Stalls the pipeline while a division runs, then commits quotient to LO and remainder to HI.

---
 rtl/hilo_div.sv | 173 +++++++++++++++++
 tb/tb_hilo_div.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div.sv
// HI/LO register pair with an iterative restoring divider for DIV/DIVU.
// Optional macro HILO_BYPASS_EN: forward pending HI/LO writes to hi_o/lo_o combinationally.
module hilo_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    input  logic             div_start_i,
    input  logic             div_signed_i,
    input  logic             div_annul_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             div_stall_o,
    output logic             div_done_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [AW-1:0]    acc, acc_nxt, acc_shift, acc_step;
    logic [WIDTH-1:0] dvsr, dvsr_nxt;
    logic             neg_q, neg_q_nxt, neg_r, neg_r_nxt;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             start_ok;
    logic             commit;
    logic [WIDTH-1:0] dividend_abs, divisor_abs;
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] quo_raw, rem_raw, quo_fix, rem_fix;
    logic             unused_acc_msb;

    assign start_ok = div_start_i && !div_annul_i;

    assign dividend_abs = (div_signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign divisor_abs  = (div_signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    // acc holds {partial remainder, dividend bits being consumed / quotient bits shifted in}.
    assign acc_shift = {acc[AW-2:0], 1'b0};
    assign trial_ge  = acc_shift[AW-1:WIDTH] >= {1'b0, dvsr};
    assign trial     = acc_shift[AW-1:WIDTH] - {1'b0, dvsr};
    assign acc_step  = trial_ge ? {trial, acc_shift[WIDTH-1:1], 1'b1} : acc_shift;

    assign quo_raw        = acc[WIDTH-1:0];
    assign rem_raw        = acc[2*WIDTH-1:WIDTH];
    assign unused_acc_msb = acc[AW-1];
    assign quo_fix        = neg_q ? -quo_raw : quo_raw;
    assign rem_fix        = neg_r ? -rem_raw : rem_raw;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned (no latches).
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        dvsr_nxt    = dvsr;
        neg_q_nxt   = neg_q;
        neg_r_nxt   = neg_r;
        div_stall_o = 1'b0;
        div_done_o  = 1'b0;
        commit      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    div_stall_o = 1'b1;
                    if (divisor_i == '0) begin
                        // Divide-by-zero result is preloaded raw: quotient all-ones, remainder = dividend.
                        state_nxt = S_DIVZERO;
                        acc_nxt   = {1'b0, dividend_i, {WIDTH{1'b1}}};
                        dvsr_nxt  = '0;
                        neg_q_nxt = 1'b0;
                        neg_r_nxt = 1'b0;
                    end else begin
                        state_nxt = S_ON;
                        cnt_nxt   = '0;
                        acc_nxt   = {{(WIDTH + 1){1'b0}}, dividend_abs};
                        dvsr_nxt  = divisor_abs;
                        neg_q_nxt = div_signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        neg_r_nxt = div_signed_i && dividend_i[WIDTH-1];
                    end
                end
            end
            S_DIVZERO: begin
                div_stall_o = 1'b1;
                state_nxt   = S_END;
            end
            S_ON: begin
                div_stall_o = 1'b1;
                acc_nxt     = acc_step;
                cnt_nxt     = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = S_END;
                end
            end
            S_END: begin
                commit     = !div_annul_i;
                div_done_o = !div_annul_i;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (div_annul_i && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            // NOTE: the datapath registers are reset too; they are few, and a known value keeps X out of hi_o/lo_o.
            acc   <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            dvsr  <= dvsr_nxt;
            neg_q <= neg_q_nxt;
            neg_r <= neg_r_nxt;
        end
    end

    // The divider result belongs to a younger instruction than the WB write, so it wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
        end else if (we_i) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

`ifdef HILO_BYPASS_EN
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (commit) begin
            hi_o = rem_fix;
            lo_o = quo_fix;
        end else if (we_i) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_div.sv
// Scoreboard bench for hilo_div: stimulus queues expected HI/LO, a monitor checks on each done pulse.
module tb_hilo_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [31:0] hi_i, lo_i;
    logic [31:0] hi_o, lo_o;
    logic        div_start_i, div_signed_i, div_annul_i;
    logic [31:0] dividend_i, divisor_i;
    logic        div_stall_o, div_done_o;

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    hilo_div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .we_i         (we_i),
        .hi_i         (hi_i),
        .lo_i         (lo_i),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .div_start_i  (div_start_i),
        .div_signed_i (div_signed_i),
        .div_annul_i  (div_annul_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .div_stall_o  (div_stall_o),
        .div_done_o   (div_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: on each done pulse pop the expected {HI,LO} and compare the cycle after commit.
    always @(negedge clk) begin
        #2;
        if (rst && div_done_o) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                mon_exp = exp_q.pop_front();
                @(negedge clk);
                #2;
                check("div_hi", {32'h0, hi_o}, {32'h0, mon_exp[63:32]});
                check("div_lo", {32'h0, lo_o}, {32'h0, mon_exp[31:0]});
            end
        end
    end

    // Issue a division, measure stall cycles and start-to-done latency, optionally collide a WB write with END.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input int elat, input logic collide);
        int k;
        int stalls;
        bit seen;
        exp_q.push_back({ehi, elo});
        div_start_i  = 1'b1;
        div_signed_i = sgn;
        dividend_i   = a;
        divisor_i    = b;
        #1;
        check("start_stall", {63'h0, div_stall_o}, 64'h1);
        stalls = 1;
        k      = 0;
        seen   = 1'b0;
        tick();
        div_start_i = 1'b0;
        while (k < 100 && !seen) begin
            k++;
            #1;
            if (div_done_o) begin
                seen = 1'b1;
                check("end_stall", {63'h0, div_stall_o}, 64'h0);
                if (collide) begin
                    we_i = 1'b1;
                    hi_i = 32'h0000AAAA;
                    lo_i = 32'h00005555;
                end
            end else begin
                if (div_stall_o) stalls++;
                tick();
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d expected=%0d", k, elat);
        end else begin
            check("done_latency", 64'(k), 64'(elat));
            check("stall_cycles", 64'(stalls), 64'(elat));
        end
        tick();
        we_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int dc;
        rst          = 1'b0;
        we_i         = 1'b0;
        hi_i         = '0;
        lo_i         = '0;
        div_start_i  = 1'b0;
        div_signed_i = 1'b0;
        div_annul_i  = 1'b0;
        dividend_i   = '0;
        divisor_i    = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hi", {32'h0, hi_o}, 64'h0);
        check("rst_lo", {32'h0, lo_o}, 64'h0);
        check("rst_stall", {63'h0, div_stall_o}, 64'h0);
        check("rst_done", {63'h0, div_done_o}, 64'h0);
        rst = 1'b1;
        tick();

        we_i = 1'b1;
        hi_i = 32'h12345678;
        lo_i = 32'h9ABCDEF0;
        #1;
`ifdef HILO_BYPASS_EN
        check("wr_same_hi", {32'h0, hi_o}, 64'h12345678);
        check("wr_same_lo", {32'h0, lo_o}, 64'h9ABCDEF0);
`else
        check("wr_same_hi", {32'h0, hi_o}, 64'h0);
        check("wr_same_lo", {32'h0, lo_o}, 64'h0);
`endif
        tick();
        we_i = 1'b0;
        hi_i = '0;
        lo_i = '0;
        #1;
        check("wr_next_hi", {32'h0, hi_o}, 64'h12345678);
        check("wr_next_lo", {32'h0, lo_o}, 64'h9ABCDEF0);
        tick();

        run_div(1'b0, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 33, 1'b0);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
        run_div(1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0);
        run_div(1'b0, 32'h00000055, 32'd0,        32'h00000055, 32'hFFFFFFFF, 2,  1'b0);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        div_start_i  = 1'b1;
        div_signed_i = 1'b0;
        dividend_i   = 32'd100;
        divisor_i    = 32'd7;
        tick();
        div_start_i = 1'b0;
        repeat (9) tick();
        div_annul_i = 1'b1;
        tick();
        div_annul_i = 1'b0;
        #1;
        check("annul_stall", {63'h0, div_stall_o}, 64'h0);
        dc = done_count;
        repeat (40) tick();
        check("annul_no_done", 64'(done_count), 64'(dc));
        check("annul_hi", {32'h0, hi_o}, 64'h0);
        check("annul_lo", {32'h0, lo_o}, 64'h0);
        run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);

        run_div(1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 33, 1'b1);

        div_start_i  = 1'b1;
        div_signed_i = 1'b0;
        dividend_i   = 32'h1000;
        divisor_i    = 32'd3;
        tick();
        div_start_i = 1'b0;
        repeat (5) tick();
        #3;
        rst = 1'b0;
        #1;
        check("midrst_hi", {32'h0, hi_o}, 64'h0);
        check("midrst_lo", {32'h0, lo_o}, 64'h0);
        check("midrst_stall", {63'h0, div_stall_o}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_div(1'b0, 32'h1000, 32'd3, 32'd1, 32'h00000555, 33, 1'b0);

        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
